// File: rtl/apbdma_downsizer.sv
// apbdma_downsizer: splits wide data/strobe words into LSB-first narrow beats with a last tag; define APBDMA_DOWNSIZER_SKIP_EN to drop all-zero-strobe beats
module apbdma_downsizer #(
  parameter int InDataWidth = 64,
  parameter int OutDataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [InDataWidth-1:0]    data_i,
  input  logic [InDataWidth/8-1:0]  strb_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [OutDataWidth-1:0]   data_o,
  output logic [OutDataWidth/8-1:0] strb_o,
  output logic                      last_o,
  output logic                      valid_o,
  input  logic                      ready_i
);
  localparam int Ratio = InDataWidth / OutDataWidth;
  localparam int IW = $clog2(Ratio);
  localparam int SW = OutDataWidth / 8;
  typedef enum logic {Idle, Busy} state_t;
  if (Ratio < 2 || (Ratio & (Ratio - 1)) != 0 || InDataWidth != Ratio * OutDataWidth || OutDataWidth % 8 != 0) begin : g_bad_ratio
    $error("apbdma_downsizer: InDataWidth/OutDataWidth must be a power of two >= 2");
  end
  state_t            state_q;
  logic [InDataWidth-1:0]   word_q;
  logic [InDataWidth/8-1:0] wstrb_q;
  logic [IW-1:0]     idx_q, first_idx, next_idx;
  logic              first_any, more, busy;
  assign busy    = state_q == Busy;
  assign data_o  = word_q[idx_q*OutDataWidth +: OutDataWidth];
  assign strb_o  = wstrb_q[idx_q*SW +: SW];
  assign valid_o = busy;
  assign last_o  = busy && !more;
  assign ready_o = !rst_i && (!busy || (last_o && ready_i));
`ifdef APBDMA_DOWNSIZER_SKIP_EN
  logic [Ratio-1:0] nz, nz_in;
  // priority search for the lowest non-empty slice of the incoming word and above the current beat
  always_comb begin
    nz = '0;
    nz_in = '0;
    first_idx = '0;
    first_any = 1'b0;
    next_idx = idx_q;
    more = 1'b0;
    for (int k = Ratio - 1; k >= 0; k--) begin
      nz[k] = |wstrb_q[k*SW +: SW];
      nz_in[k] = |strb_i[k*SW +: SW];
      if (nz_in[k]) begin
        first_idx = IW'(k);
        first_any = 1'b1;
      end
      if (nz[k] && k > int'(idx_q)) begin
        next_idx = IW'(k);
        more = 1'b1;
      end
    end
  end
`else
  assign first_idx = '0;
  assign first_any = 1'b1;
  assign next_idx  = idx_q + IW'(1);
  assign more      = idx_q != IW'(Ratio - 1);
`endif
  // acceptance outranks completion so consecutive words stream without a bubble
  always_ff @(posedge clk_i)
    if (rst_i) begin
      state_q <= Idle;
      idx_q <= '0;
      word_q <= '0;
      wstrb_q <= '0;
    end else if (valid_i && ready_o) begin
      word_q <= data_i;
      wstrb_q <= strb_i;
      idx_q <= first_idx;
      state_q <= first_any ? Busy : Idle;
    end else if (busy && ready_i && more) idx_q <= next_idx;
    else if (busy && ready_i) state_q <= Idle;
endmodule
